// File: rtl/karnaugh_sweep.sv
// Sweeps a,b,c,d through all 16 vectors, samples the POS block output, and builds a truth table plus a minterm count.
// Optional self-check ports are enabled by defining KARNAUGH_SWEEP_CHECK_EN.
module karnaugh_sweep #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        o_in,
`ifdef KARNAUGH_SWEEP_CHECK_EN
  input  logic [15:0] expected,
  output logic        mismatch,
  output logic [15:0] mismatch_mask,
`endif
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  minterm_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t     state, state_d;
  logic [3:0] idx;
  logic [3:0] cnt;
  logic       clear, sample, cnt_dec;

  always_comb begin
    state_d = state;
    clear   = 1'b0;
    sample  = 1'b0;
    cnt_dec = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d = SETTLE;
          clear   = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt == 4'd1) state_d = SAMPLE;
        else             cnt_dec = 1'b1;
      end
      SAMPLE: begin
        sample  = 1'b1;
        state_d = (idx == 4'd15) ? DONE : SETTLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      cnt           <= '0;
      truth_table   <= '0;
      minterm_count <= '0;
`ifdef KARNAUGH_SWEEP_CHECK_EN
      mismatch_mask <= '0;
`endif
    end else begin
      state <= state_d;
      if (clear) begin
        idx           <= '0;
        cnt           <= SETTLE_INIT;
        truth_table   <= '0;
        minterm_count <= '0;
`ifdef KARNAUGH_SWEEP_CHECK_EN
        mismatch_mask <= '0;
`endif
      end
      if (cnt_dec) cnt <= cnt - 4'd1;
      if (sample) begin
        truth_table[idx] <= o_in;
        minterm_count    <= minterm_count + {4'd0, o_in};
`ifdef KARNAUGH_SWEEP_CHECK_EN
        mismatch_mask[idx] <= o_in ^ expected[idx];
`endif
        // idx parks at 15 so the vector outputs read 4'b1111 in DONE
        if (idx != 4'd15) begin
          idx <= idx + 4'd1;
          cnt <= SETTLE_INIT;
        end
      end
    end
  end

  assign {a, b, c, d} = idx;
  assign busy = (state == SETTLE) || (state == SAMPLE);
  assign done = (state == DONE);
`ifdef KARNAUGH_SWEEP_CHECK_EN
  assign mismatch = |mismatch_mask;
`endif

endmodule

// File: tb/tb_karnaugh_sweep.sv
// Directed bench for karnaugh_sweep: reset, default sweep, busy-start, restart, mid-sweep reset, SETTLE_CYCLES=3.
module tb_karnaugh_sweep;

  logic        clk = 1'b0;
  logic        reset, start, start3, glitch;
  logic [15:0] pat;
  logic        o_in;
  logic        a, b, c, d, busy, done;
  logic [15:0] truth_table;
  logic [4:0]  minterm_count;
  logic        a3, b3, c3, d3, busy3, done3;
  logic [15:0] truth_table3;
  logic [4:0]  minterm_count3;
  logic [3:0]  abcd;
`ifdef KARNAUGH_SWEEP_CHECK_EN
  logic [15:0] expected;
  logic        mismatch, mismatch3;
  logic [15:0] mismatch_mask, mismatch_mask3;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign abcd = {a, b, c, d};
  // POS block stand-in: truth table lookup, optionally inverted to emulate unsettled output
  assign o_in = glitch ? ~pat[abcd] : pat[abcd];

  karnaugh_sweep dut (
    .clk(clk), .reset(reset), .start(start), .o_in(o_in),
`ifdef KARNAUGH_SWEEP_CHECK_EN
    .expected(expected), .mismatch(mismatch), .mismatch_mask(mismatch_mask),
`endif
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done),
    .truth_table(truth_table), .minterm_count(minterm_count)
  );

  karnaugh_sweep #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .o_in(1'b1),
`ifdef KARNAUGH_SWEEP_CHECK_EN
    .expected(16'hFFFF), .mismatch(mismatch3), .mismatch_mask(mismatch_mask3),
`endif
    .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3),
    .truth_table(truth_table3), .minterm_count(minterm_count3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start3 = 1'b0; glitch = 1'b0; pat = '0;
`ifdef KARNAUGH_SWEEP_CHECK_EN
    expected = 16'hA5C3;
`endif
    tick(); tick();
    reset = 1'b0;
    repeat (10) tick();
    check("rst_abcd", 32'(abcd), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_tt", 32'(truth_table), 0);
    check("rst_mc", 32'(minterm_count), 0);
    check("rst_busy3", 32'(busy3), 0);
    check("rst_abcd3", 32'({a3, b3, c3, d3}), 0);

    // default sweep
    pat = 16'hA5C3;
    start = 1'b1; tick(); start = 1'b0;
    check("s1_busy", 32'(busy), 1);
    check("s1_abcd0", 32'(abcd), 0);
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k % 2 == 0 && k < 32) check("s1_step_abcd", 32'(abcd), 32'(k / 2));
      if (k == 31) check("s1_done_early", 32'(done), 0);
    end
    check("s1_done", 32'(done), 1);
    check("s1_busy_end", 32'(busy), 0);
    check("s1_tt", 32'(truth_table), 32'hA5C3);
    check("s1_mc", 32'(minterm_count), 8);
    check("s1_abcd_end", 32'(abcd), 15);
`ifdef KARNAUGH_SWEEP_CHECK_EN
    check("s1_mismatch", 32'(mismatch), 0);
`endif

    // restart from DONE, with a start pulse mid-sweep that must be ignored
    pat = 16'h1234;
    start = 1'b1; tick(); start = 1'b0;
    check("s2_done_clr", 32'(done), 0);
    check("s2_busy", 32'(busy), 1);
    check("s2_abcd0", 32'(abcd), 0);
    check("s2_tt_clr", 32'(truth_table), 0);
    check("s2_mc_clr", 32'(minterm_count), 0);
    for (int k = 1; k <= 32; k++) begin
      if (k == 10) start = 1'b1;
      tick();
      start = 1'b0;
      if (k == 31) check("s2_done_early", 32'(done), 0);
    end
    check("s2_done", 32'(done), 1);
    check("s2_tt", 32'(truth_table), 32'h1234);
    check("s2_mc", 32'(minterm_count), 5);

    // reset mid-sweep, with start asserted alongside
    start = 1'b1; tick(); start = 1'b0;
    repeat (14) tick();
    check("s3_abcd7", 32'(abcd), 7);
    reset = 1'b1; start = 1'b1; tick();
    check("s3_rst_abcd", 32'(abcd), 0);
    check("s3_rst_busy", 32'(busy), 0);
    check("s3_rst_done", 32'(done), 0);
    check("s3_rst_tt", 32'(truth_table), 0);
    check("s3_rst_mc", 32'(minterm_count), 0);
    reset = 1'b0; start = 1'b0; tick();
    check("s3_no_start", 32'(busy), 0);

    // fresh sweep; o_in is inverted on every non-capture edge
    pat = 16'h8001;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      glitch = (k % 2 == 1);
      tick();
    end
    glitch = 1'b0;
    check("s4_done", 32'(done), 1);
    check("s4_tt", 32'(truth_table), 32'h8001);
    check("s4_mc", 32'(minterm_count), 2);

    // SETTLE_CYCLES = 3, o_in tied high
    start3 = 1'b1; tick(); start3 = 1'b0;
    check("s5_busy", 32'(busy3), 1);
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 7) check("s5_abcd1", 32'({a3, b3, c3, d3}), 1);
      if (k == 63) check("s5_done_early", 32'(done3), 0);
    end
    check("s5_done", 32'(done3), 1);
    check("s5_tt", 32'(truth_table3), 32'hFFFF);
    check("s5_mc", 32'(minterm_count3), 16);

`ifdef KARNAUGH_SWEEP_CHECK_EN
    pat = 16'hA5C2;
    expected = 16'hA5C3;
    start = 1'b1; tick(); start = 1'b0;
    check("s6_mismatch_clr", 32'(mismatch), 0);
    repeat (32) tick();
    check("s6_done", 32'(done), 1);
    check("s6_mismatch", 32'(mismatch), 1);
    check("s6_mask", 32'(mismatch_mask), 32'h0001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
